// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: shared state encoding and default widths for the delay-chain latency meter
package delay_meter_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, WAIT, NEXT, FINISH, ABORT} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int RUNS_LOG2_DEF = 3;
  localparam int SUM_W_DEF = CNT_W_DEF + RUNS_LOG2_DEF;
endpackage

// File: rtl/delay_meter_sync_chain.sv
// sync_chain: STAGES-deep flop synchronizer, async active-low reset to 0
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else ff_q <= ff_d;
  end
  assign q = ff_q[STAGES-1];
endmodule

// File: rtl/delay_meter.sv
// delay_meter: launches edges into a delay chain and reports min/max/avg latency over a batch
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int              CNT_W       = CNT_W_DEF,
  parameter int              SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = 16'hFFF0,
  parameter int              SETTLE_CYC  = 4,
  parameter int              RUNS_LOG2   = RUNS_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             chain_dout,
  output logic             chain_din,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] min_cnt,
  output logic [CNT_W-1:0] max_cnt,
  output logic [CNT_W-1:0] avg_cnt
);
  localparam int SUM_W = CNT_W + RUNS_LOG2;
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);

  state_t state_q, state_d;
  logic sync_q, match, settled, cnt_hit, last_run;
  logic [CNT_W-1:0] cnt_q, cnt_d, min_acc_q, min_acc_d, max_acc_q, max_acc_d;
  logic [CNT_W-1:0] min_cnt_q, min_cnt_d, max_cnt_q, max_cnt_d, avg_cnt_q, avg_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [ST_W-1:0] stab_q, stab_d;
  logic [RUNS_LOG2-1:0] run_q, run_d;
  logic chain_din_q, chain_din_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (chain_dout),
    .q    (sync_q)
  );

  assign match    = sync_q == chain_din_q;
  assign settled  = match && stab_q == ST_W'(SETTLE_CYC - 1);
  assign cnt_hit  = cnt_q == TIMEOUT_CYC;
  assign last_run = run_q == '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stab_q      <= '0;
      run_q       <= '0;
      sum_q       <= '0;
      min_acc_q   <= '0;
      max_acc_q   <= '0;
      chain_din_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      min_cnt_q   <= '0;
      max_cnt_q   <= '0;
      avg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      run_q       <= run_d;
      sum_q       <= sum_d;
      min_acc_q   <= min_acc_d;
      max_acc_q   <= max_acc_d;
      chain_din_q <= chain_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      min_cnt_q   <= min_cnt_d;
      max_cnt_q   <= max_cnt_d;
      avg_cnt_q   <= avg_cnt_d;
    end
  end

  // A timeout wins over a late match, keeping every captured count below TIMEOUT_CYC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          state_d = start ? SETTLE : IDLE;
      SETTLE:        state_d = settled ? LAUNCH : (cnt_hit ? ABORT : SETTLE);
      LAUNCH:        state_d = WAIT;
      WAIT:          state_d = cnt_hit ? ABORT : (match ? NEXT : WAIT);
      NEXT:          state_d = last_run ? FINISH : SETTLE;
      FINISH, ABORT: state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_hit ? cnt_q : cnt_q + CNT_W'(1);
    stab_d      = stab_q;
    run_d       = run_q;
    sum_d       = sum_q;
    min_acc_d   = min_acc_q;
    max_acc_d   = max_acc_q;
    chain_din_d = chain_din_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    min_cnt_d   = min_cnt_q;
    max_cnt_d   = max_cnt_q;
    avg_cnt_d   = avg_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        busy_d    = 1'b1;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        run_d     = '0;
        sum_d     = '0;
        min_acc_d = '1;
        max_acc_d = '0;
        cnt_d     = '0;
        stab_d    = '0;
      end
      SETTLE: stab_d = match ? stab_q + ST_W'(1) : '0;
      LAUNCH: begin
        chain_din_d = ~chain_din_q;
        cnt_d       = '0;
      end
      WAIT: if (match && !cnt_hit) begin
        sum_d     = sum_q + SUM_W'(cnt_q);
        min_acc_d = cnt_q < min_acc_q ? cnt_q : min_acc_q;
        max_acc_d = cnt_q > max_acc_q ? cnt_q : max_acc_q;
      end
      NEXT: begin
        cnt_d  = '0;
        stab_d = '0;
        run_d  = last_run ? run_q : run_q + RUNS_LOG2'(1);
      end
      FINISH: begin
        min_cnt_d = min_acc_q;
        max_cnt_d = max_acc_q;
        avg_cnt_d = sum_q[SUM_W-1:RUNS_LOG2];
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      ABORT: begin
        timeout_d   = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        chain_din_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign chain_din = chain_din_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign min_cnt   = min_cnt_q;
  assign max_cnt   = max_cnt_q;
  assign avg_cnt   = avg_cnt_q;
endmodule
